// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and flush-to-bubble.
// SKID=1 adds a second entry so in_ready comes straight from a flop.
module pipe_stage_buf #(
  parameter int               WIDTH     = 160,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  generate
    if (SKID) begin : gSkid
      state_e           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             ready_q;
      logic             push, pop;

      assign push = in_valid & ready_q;
      assign pop  = (state_q != EMPTY) & out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (push) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_d = in_data;
            end else if (push) begin
              state_d = TWO;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        // Flush wins; a popped head has already been handed downstream.
        if (flush) begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
        end
      end

      // ready_q is computed from the next state so it is a clean flop output.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= EMPTY;
          main_q  <= NOP_VALUE;
          skid_q  <= NOP_VALUE;
          ready_q <= 1'b1;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= (state_d != TWO);
        end
      end

      assign in_ready  = ready_q;
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
      assign occupancy = state_q;
    end else begin : gSingle
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic             push, pop;

      assign in_ready = ~valid_q | out_ready;
      assign push     = in_valid & in_ready;
      assign pop      = valid_q & out_ready;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (push) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (pop) begin
          valid_d = 1'b0;
        end
        if (flush) begin
          valid_d = 1'b0;
          main_d  = NOP_VALUE;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          main_q  <= NOP_VALUE;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. It replaces the fixed-field, enable-only stage registers between CPU stages: the payload width is a parameter, and stalls are expressed by back-pressure instead of a global enable. With `SKID=1`, `in_ready` is a pure register output, so stall paths no longer chain combinationally across stages.

## Interface
Parameters:
- `WIDTH`, 160: payload bits, e.g. 5×32 for Instr, pc, ALUout, DMout, MD_out.
- `NOP_VALUE`, {WIDTH{1'b0}}: payload presented on `out_data` after reset or flush.
- `SKID`, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage accepts this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `flush`  in  1  synchronous kill of all held entries and of any same-cycle push.
- `out_valid`  out  1  `out_data` is a live entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  WIDTH  head-of-stage payload.
- `occupancy`  out  2  number of held entries: 0..2, or 0..1 when `SKID=0`.

## Operation
- Push: `in_valid & in_ready` at a rising edge. Pop: `out_valid & out_ready` at a rising edge.
- Storage is a main register (drives `out_data`) plus, when `SKID=1`, a skid register. Order is strictly FIFO.
- `SKID=1` state machine, encoded in `occupancy`:
  - EMPTY:
    - push → ONE, main ← `in_data`.
  - ONE:
    - push & pop → ONE, main ← `in_data`.
    - push only → TWO, skid ← `in_data`.
    - pop only → EMPTY.
  - TWO:
    - pop → ONE, main ← skid.
    - No push is possible because `in_ready`=0.
- In `SKID=1` mode, `in_ready` = (state != TWO). It is a flop output with no combinational path from `out_ready`.
- `SKID=0`:
  - `in_ready` = `!out_valid | out_ready` (combinational).
  - On push, main ← `in_data`.
  - On pop without push, the stage goes empty.
- `out_valid` = (occupancy != 0).
- Pop to EMPTY leaves `out_data` unchanged (stale, but `out_valid`=0).
- Flush has priority over everything:
  - Next state is EMPTY.
  - main ← `NOP_VALUE`; skid contents are don't-care.
  - A same-cycle push handshakes (upstream may retire it) but its data is discarded.
  - A same-cycle pop is still delivered downstream.
- Reset, asynchronous at any time including mid-transfer:
  - `occupancy`=0, `out_valid`=0, `out_data`=`NOP_VALUE`.
  - `in_ready`=1 in both modes; in `SKID=0` this follows from `out_valid`=0.
  - Any partially held entries are lost.
- Payload is opaque: no arithmetic, and no width conversion beyond `WIDTH`.

## Timing
- Latency: a push at edge N is visible on `out_data` with `out_valid`=1 after edge N (one cycle), in both modes.
- Throughput is 1 entry/cycle when `out_ready` is held high.
- `SKID=1`, downstream stalls:
  - The first stalled push lands in skid and `in_ready` falls after that edge.
  - When `out_ready` rises, the stage drains skid → main. `in_ready` rises the cycle after that pop, so no beat is lost.
- Outputs change only on the rising `clk` edge or the assertion of `reset`. Release of `reset` is synchronised externally.
- `flush` takes effect at the edge where it is sampled. After that edge `out_valid`=0 and `in_ready`=1.

## Test plan
- Reset: assert `reset` mid-cycle while `occupancy`=2 → immediately `out_valid`=0, `occupancy`=0, `out_data`=0, `in_ready`=1, with no clock needed.
- Streaming, `SKID=1`: push 0x1..0x8 on consecutive cycles with `out_ready`=1 → `out_data` sequence 0x1..0x8, each one cycle after push, `in_ready` constantly 1.
- Back-pressure, `SKID=1`:
  - Push 0xA, 0xB, 0xC with `out_ready`=0 → `occupancy` 1 then 2, `in_ready`=0 after 0xB, 0xC held upstream.
  - Then `out_ready`=1 → outputs 0xA, 0xB, 0xC in order, none dropped or duplicated.
- Flush: `occupancy`=2 with 0x5, 0x6, then `flush`=1 while pushing 0x7 and popping 0x5 → 0x5 consumed, next cycle `out_valid`=0, `out_data`=`NOP_VALUE`, 0x7 never appears.
- `SKID=0` stall: hold 0x3 with `out_ready`=0 → `in_ready`=0 combinationally; raise `out_ready` with `in_valid` and 0x4 in the same cycle → 0x4 replaces 0x3 at the edge, `occupancy` stays 1.
- Parameter sweep: `WIDTH`=1, 32, 160 and `NOP_VALUE`=0x00000000 vs 0xDEADBEEF (`WIDTH`=32) → reset and flush present the configured `NOP_VALUE`.
